// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-high (1 lights a segment).
package seg7_pkg;

  localparam int NUM_POS = 6;
  localparam int NUM_DIG = 5;

  typedef logic [2:0] pos_t;
  typedef logic [6:0] seg_t;

  localparam pos_t SIGN_POS = 3'd5;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_MINUS = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  // Sign flag plus five BCD digits; dig[0] is the ones digit.
  typedef struct packed {
    logic                        neg;
    logic [NUM_DIG-1:0][3:0]     dig;
  } disp_t;

  function automatic seg_t seg_pol(
    input seg_t p,
    input logic inv
  );
    return inv ? ~p : p;
  endfunction

  function automatic logic [3:0] dig_at(
    input disp_t d,
    input pos_t  p
  );
    logic [3:0] r;
    case (p)
      3'd0:    r = d.dig[0];
      3'd1:    r = d.dig[1];
      3'd2:    r = d.dig[2];
      3'd3:    r = d.dig[3];
      3'd4:    r = d.dig[4];
      default: r = 4'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Combinational BCD to seven-segment decoder, active-high output.
// Ports: code_i (4b digit code), blank_i (force blank), seg_o (pattern).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  seg_t pat;

  always_comb begin
    pat = SEG_E;
    case (code_i)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_E;
    endcase
  end

  assign seg_o = blank_i ? SEG_BLANK : pat;

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-position multiplexed seven-segment driver (sign + five BCD digits).
// Ports: clk, rst_n, load/negative/bcd_digit0..4 in; an, seg, frame_done out.
// Optional macro SEG7_LZ_BLANK_EN enables leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               negative,
  input  logic [3:0]         bcd_digit0,
  input  logic [3:0]         bcd_digit1,
  input  logic [3:0]         bcd_digit2,
  input  logic [3:0]         bcd_digit3,
  input  logic [3:0]         bcd_digit4,
  output logic [NUM_POS-1:0] an,
  output logic [6:0]         seg,
  output logic               frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  localparam logic [NUM_POS-1:0] AN_OFF =
    AN_INV ? {NUM_POS{1'b1}} : {NUM_POS{1'b0}};
  localparam seg_t SEG_OFF =
    SEG_INV ? 7'h7F : 7'h00;

  logic [PW-1:0]      pre_q, pre_d;
  pos_t               idx_q, idx_d;
  logic               lit_q, lit_d;
  disp_t              pend_q, pend_d;
  disp_t              disp_q, disp_d;
  logic [NUM_POS-1:0] an_q, an_d;
  seg_t               seg_q, seg_d;
  logic               fd_q, fd_d;

  disp_t              in_w;
  logic               tick;
  logic               wrap;
  logic [3:0]         code;
  logic [NUM_POS-1:0] lz;
  logic               blank;
  seg_t               dec_pat;
  seg_t               pat;
  logic [NUM_POS-1:0] an_on;

  assign in_w = {negative,
                 bcd_digit4,
                 bcd_digit3,
                 bcd_digit2,
                 bcd_digit1,
                 bcd_digit0};

  assign tick = (pre_q == PW'(REFRESH_DIV - 1));

  // The first tick after reset only lights position 0;
  // later ticks advance the scan.
  assign wrap = tick && lit_q &&
                (idx_q == SIGN_POS);

  always_comb begin
    pre_d  = tick ? '0 : pre_q + PW'(1);
    lit_d  = lit_q | tick;
    pend_d = load ? in_w : pend_q;
    idx_d  = idx_q;
    if (tick && lit_q) begin
      idx_d = (idx_q == SIGN_POS)
            ? pos_t'(0)
            : idx_q + pos_t'(1);
    end
    // A load on the boundary cycle bypasses pending.
    disp_d = disp_q;
    if (wrap) begin
      disp_d = load ? in_w : pend_q;
    end
    fd_d = wrap;
  end

`ifdef SEG7_LZ_BLANK_EN
  // lz[i]: digit i and every higher digit are zero.
  always_comb begin
    lz = '0;
    lz[NUM_DIG-1] = (disp_d.dig[NUM_DIG-1] == 4'h0);
    for (int i = NUM_DIG - 2; i >= 1; i--) begin
      lz[i] = lz[i+1] &&
              (disp_d.dig[i] == 4'h0);
    end
  end
`else
  always_comb begin
    lz = '0;
  end
`endif

  assign code  = dig_at(disp_d, idx_d);
  assign blank = lz[idx_d];

  seg7_decode u_dec (
    .code_i  (code),
    .blank_i (blank),
    .seg_o   (dec_pat)
  );

  always_comb begin
    pat = dec_pat;
    if (idx_d == SIGN_POS) begin
      pat = disp_d.neg ? SEG_MINUS
                       : SEG_BLANK;
    end
  end

  assign an_on = NUM_POS'(1) << idx_d;

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      an_d  = AN_INV ? ~an_on : an_on;
      seg_d = seg_pol(pat, SEG_INV);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      idx_q  <= '0;
      lit_q  <= 1'b0;
      pend_q <= '0;
      disp_q <= '0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      fd_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      lit_q  <= lit_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      fd_q   <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV=4.
// Expected slots come from a cycle-count model of the scan timing.
module tb_seg7_scan_driver;

  localparam int DIV = 4;
  localparam int FRM = 6 * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic       negative;
  logic [3:0] d0, d1, d2, d3, d4;
  logic [5:0] an;
  logic [6:0] seg;
  logic       frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV    (DIV),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .negative   (negative),
    .bcd_digit0 (d0),
    .bcd_digit1 (d1),
    .bcd_digit2 (d2),
    .bcd_digit3 (d3),
    .bcd_digit4 (d4),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Model: k counts rising edges since reset release.
  int         k;
  logic       m_neg;
  logic [3:0] m_last[5];
  logic       s_neg;
  logic [3:0] s_dig[5];
  bit         mon_en = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] want
  );
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, want, $time);
    end
  endtask

  function automatic logic [6:0] pat_of(input int c);
    case (c)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  task automatic model_clear();
    m_neg = 1'b0;
    s_neg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_last[i] = 4'h0;
      s_dig[i]  = 4'h0;
    end
  endtask

  task automatic push_exp();
    int   s;
    int   pos;
    bit   fd;
    logic [6:0] p;
    exp_t e;
    s   = k / DIV;
    pos = (s - 1) % 6;
    fd  = (pos == 0) && (s > 1);
    if (fd) begin
      s_neg = m_neg;
      s_dig = m_last;
    end
    if (pos == 5) begin
      p = s_neg ? 7'h40 : 7'h00;
    end else begin
      p = pat_of(int'(s_dig[pos]));
`ifdef SEG7_LZ_BLANK_EN
      if (pos >= 1) begin
        bit allz;
        allz = 1;
        for (int j = pos; j < 5; j++)
          if (s_dig[j] != 0) allz = 0;
        if (allz) p = 7'h00;
      end
`endif
    end
    e.an  = ~(6'(1) << pos);
    e.seg = ~p;
    e.fd  = fd;
    exp_q.push_back(e);
  endtask

  task automatic cyc(
    input logic        ld,
    input logic        ng,
    input logic [19:0] dg
  );
    @(negedge clk);
    load     = ld;
    negative = ng;
    {d4, d3, d2, d1, d0} = dg;
    k++;
    if (ld) begin
      m_neg = ng;
      for (int i = 0; i < 5; i++)
        m_last[i] = dg[i*4 +: 4];
    end
    if (k % DIV == 0) push_exp();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 20'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    chk("rst_an", an, 6'h3F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_fd", frame_done, 1'b0);
    exp_q.delete();
    k = 0;
    model_clear();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: each change of an is one presented slot.
  initial begin
    logic [5:0] prev_an;
    logic [6:0] prev_seg;
    exp_t       e;
    prev_an  = 6'h3F;
    prev_seg = 7'h7F;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !mon_en) begin
        prev_an  = 6'h3F;
        prev_seg = 7'h7F;
      end else if (an !== prev_an) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slot: an=%h seg=%h, none expected",
                   an, seg);
        end else begin
          e = exp_q.pop_front();
          chk("an", an, e.an);
          chk("seg", seg, e.seg);
          chk("frame_done", frame_done, e.fd);
        end
        prev_an  = an;
        prev_seg = seg;
      end else begin
        chk("seg_hold", seg, prev_seg);
        chk("fd_idle", frame_done, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    logic [19:0] rd;
    rst_n    = 1'b0;
    load     = 1'b0;
    negative = 1'b0;
    {d4, d3, d2, d1, d0} = 20'h0;
    k = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("init_an", an, 6'h3F);
    chk("init_seg", seg, 7'h7F);
    chk("init_fd", frame_done, 1'b0);
    #2;
    rst_n  = 1'b1;
    mon_en = 1;

    idle(30);
    cyc(1'b1, 1'b1, 20'h12345);
    idle(30);

    // Load on the boundary edge itself.
    while (((k + 1 - DIV) % FRM) != 0) idle(1);
    cyc(1'b1, 1'b0, 20'h99999);
    idle(FRM + 2);

    cyc(1'b1, 1'b0, 20'h00007);
    idle(FRM + 6);
    cyc(1'b1, 1'b1, 20'h86C31);
    idle(FRM + 6);

    repeat (300) begin
      rd = 20'($urandom);
      cyc($urandom_range(0, 7) == 0,
          1'($urandom), rd);
    end
    idle(FRM);

    // Pending load then reset: pending is lost.
    cyc(1'b1, 1'b1, 20'h54321);
    idle(5);
    do_reset();
    idle(40);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the 16-bit binary-to-BCD converter. Captures its sign flag and five BCD digits, then time-multiplexes them onto a 6-position common-anode seven-segment display. Position 5 is the sign and positions 4..0 are the digits. Frame-synchronous updates prevent tearing.

Parameters:
REFRESH_DIV, 50000, clock cycles each position stays lit (minimum 2)
SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (0 lights a segment)
AN_ACTIVE_LOW, 1, 1 = an outputs inverted (0 enables a position)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load  input  1  capture strobe for negative/bcd_digit* this cycle
negative  input  1  sign from converter; 1 = show minus
bcd_digit0  input  4  ones digit
bcd_digit1  input  4  tens digit
bcd_digit2  input  4  hundreds digit
bcd_digit3  input  4  thousands digit
bcd_digit4  input  4  ten-thousands digit
an  output  6  one-hot position enable; bit 5 = sign position
seg  output  7  segments {g,f,e,d,c,b,a}, registered
frame_done  output  1  one-cycle pulse when the scan wraps from position 5 to 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - prescaler=0, position index=0, frame_done=0.
  - pending and display registers = 0 / not negative.
  - an = all positions off (6'h3F if AN_ACTIVE_LOW, else 6'h00).
  - seg = all segments off.
- Pending register: loads all 21 input bits on any cycle with load=1. The last load before a frame boundary wins.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler==REFRESH_DIV-1).
- Position index: advances on tick, 0→1→…→5→0.
- Frame boundary: tick while index==5.
  - display register ← pending register.
  - If load=1 in the same cycle, the new input values go straight to display (bypass).
  - frame_done=1 in the following cycle, for one cycle.
- an/seg update one cycle after tick (registered), showing the new index from display.
- First lit position: index 0, appearing at cycle REFRESH_DIV+1 after reset release, using display contents. Before that, outputs stay blank.
- Decode, active-high before polarity inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any code 10..15 shows E=79.
- Sign position: minus=40 if negative, else blank=00.
- Input values are never range-checked or corrected. Invalid codes only affect their own position.
- Reset asserted mid-frame aborts immediately. The pending value is lost.

Optional Feature:
SEG7_LZ_BLANK_EN
- Defined: leading-zero suppression.
  - Positions 4..1 show blank while they and every higher digit equal 0.
  - Position 0 is always shown.
  - An E code counts as non-zero.
  - Minus is still shown in position 5 only.
- Undefined: all five digits are always shown, including leading zeros.

Decomposition:
- Shared package seg7_pkg:
  - segment pattern constants (SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_BLANK)
  - NUM_POS=6
  - position index type (3 bits)
  - SIGN_POS=5
- Sub-module seg7_decode: combinational 4-bit code + blank flag → 7-bit active-high pattern.
- Top module: prescaler, index counter, pending/display registers, blanking logic, polarity inversion.

Test Plan:
- Reset release, REFRESH_DIV=4, no load → an stays off and seg blank for 4 cycles. Then an selects position 0 with seg=3F (active-high view), and each position holds for 4 cycles.
- load once with negative=1, digits 4..0 = 1,2,3,4,5 mid-frame → display unchanged until the wrap from position 5 to 0, frame_done pulses 1 cycle. The next frame shows 6D,66,4F,5B,06 on positions 0..4 and 40 on position 5.
- load coinciding with the frame-boundary tick, digits all 9 → that same new frame shows 6F on all digit positions (bypass).
- Digits 0,0,0,0,7 with SEG7_LZ_BLANK_EN defined → positions 4..1 blank and position 0 shows 07. Without the macro, positions 4..1 show 3F.
- Digit code 12 in position 2 → position 2 shows 79, all other positions correct.
- rst_n pulsed low mid-frame for 1 cycle → an/seg go off within the same cycle, index=0, frame_done=0, and a fresh display of zeros appears after REFRESH_DIV+1 cycles.
